// File: rtl/vga_line_buffer.sv
// vga_line_buffer: double-buffered scanline store between the VRAM arbiter
// and the VGA output stage. A row fetched from vram_control fills the back
// bank while the front bank feeds registered pixels to the display. The banks
// swap on the timing generator's line-boundary strobe.
module vga_line_buffer #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [8:0]  fetch_y,
  input  logic        swap,
  output logic        VGA_re,
  output logic [8:0]  VGA_y,
  input  logic        VGA_we,
  input  logic [9:0]  VGA_x,
  input  logic [23:0] VGA_data,
  input  logic [9:0]  pix_x,
  input  logic        disp_active,
  output logic [23:0] pix_data,
  output logic        busy,
  output logic        line_ready,
  output logic        underrun
);

  localparam logic [9:0] W_LIMIT = 10'(SCREEN_W);
  localparam logic [9:0] W_LAST  = 10'(SCREEN_W - 1);
  localparam logic [9:0] H_LIMIT = 10'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        vga_re_q, vga_re_d;
  logic [8:0]  vga_y_q, vga_y_d;
  logic        rd_bank_q, rd_bank_d;
  logic [23:0] pix_data_q, pix_data_d;
  logic        busy_q, busy_d;
  logic        line_ready_q, line_ready_d;
  logic        underrun_q, underrun_d;

  // Two line banks; contents are don't-care after reset.
  logic [23:0] bank0 [SCREEN_W];
  logic [23:0] bank1 [SCREEN_W];

  logic        fetch_ok;
  logic        wr_en;
  logic        last_wr;
  logic [23:0] front_pix;

  // Qualify the arbiter writes and fetch requests for this cycle.
  // Rows at or beyond SCREEN_H do not exist in the framebuffer, so such a
  // request is dropped instead of asking the arbiter for a bogus row.
  always_comb begin
    wr_en    = (state_q == S_FILL) && VGA_we && (VGA_x < W_LIMIT);
    last_wr  = (state_q == S_FILL) && VGA_we && (VGA_x == W_LAST);
    fetch_ok = fetch_req && ({1'b0, fetch_y} < H_LIMIT);
  end

  // Capture arbiter pixels into whichever bank is currently the back bank.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (rd_bank_q) begin
        bank0[VGA_x] <= VGA_data;
      end else begin
        bank1[VGA_x] <= VGA_data;
      end
    end
  end

  // Front-bank lookup; blanked outside the active region or past the row end.
  always_comb begin
    front_pix  = rd_bank_q ? bank1[pix_x] : bank0[pix_x];
    pix_data_d = '0;
    if (disp_active && (pix_x < W_LIMIT)) begin
      pix_data_d = front_pix;
    end
  end

  // Fetch/fill/swap sequencing. A swap is honoured only once the back bank
  // is complete (DONE, or the very cycle of the final write); an early swap
  // leaves the front line in place and flags a sticky underrun.
  always_comb begin
    state_d    = state_q;
    vga_y_d    = vga_y_q;
    rd_bank_d  = rd_bank_q;
    underrun_d = underrun_q;

    case (state_q)
      S_IDLE: begin
        if (swap) begin
          underrun_d = 1'b1;
        end
        if (fetch_ok) begin
          vga_y_d = fetch_y;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (swap) begin
          underrun_d = 1'b1;
        end
        state_d = S_FILL;
      end
      S_FILL: begin
        if (last_wr) begin
          if (swap) begin
            rd_bank_d = ~rd_bank_q;
            state_d   = S_IDLE;
          end else begin
            state_d   = S_DONE;
          end
        end else if (swap) begin
          underrun_d = 1'b1;
        end
      end
      S_DONE: begin
        if (swap) begin
          rd_bank_d = ~rd_bank_q;
          if (fetch_ok) begin
            vga_y_d = fetch_y;
            state_d = S_REQ;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    vga_re_d     = (state_d == S_REQ);
    busy_d       = (state_d == S_REQ) || (state_d == S_FILL);
    line_ready_d = (state_d == S_DONE);
  end

  // State and registered outputs, cleared asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vga_re_q     <= 1'b0;
      vga_y_q      <= '0;
      rd_bank_q    <= 1'b0;
      pix_data_q   <= '0;
      busy_q       <= 1'b0;
      line_ready_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      vga_re_q     <= vga_re_d;
      vga_y_q      <= vga_y_d;
      rd_bank_q    <= rd_bank_d;
      pix_data_q   <= pix_data_d;
      busy_q       <= busy_d;
      line_ready_q <= line_ready_d;
      underrun_q   <= underrun_d;
    end
  end

  assign VGA_re     = vga_re_q;
  assign VGA_y      = vga_y_q;
  assign pix_data   = pix_data_q;
  assign busy       = busy_q;
  assign line_ready = line_ready_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/vga_line_buffer.md
# vga_line_buffer

Double-buffered scanline store on the display side of the VRAM arbiter. It requests one framebuffer row from `vram_control` per line and captures the burst of `VGA_we`/`VGA_x`/`VGA_data` pixel writes into the back bank. It serves registered 24-bit pixels from the front bank to the VGA output stage. Banks swap on a line-boundary strobe from the display timing generator.

## Interface
- `SCREEN_W`, default 640: pixels per fetched row; must match the arbiter's row length.
- `SCREEN_H`, default 480: rows per frame; limits legal `fetch_y`.
- `clk`  in  1  system clock, shared with `vram_control`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_req`  in  1  one-cycle strobe: fetch row `fetch_y` into the back bank.
- `fetch_y`  in  9  row to fetch; sampled only when `fetch_req` is accepted.
- `swap`  in  1  one-cycle line-boundary strobe: promote the back bank to front.
- `VGA_re`  out  1  row request to the arbiter.
- `VGA_y`  out  9  row being fetched; held stable for the entire fill.
- `VGA_we`  in  1  pixel write strobe from the arbiter.
- `VGA_x`  in  10  write column.
- `VGA_data`  in  24  RGB888 pixel.
- `pix_x`  in  10  display column to read.
- `disp_active`  in  1  display in active region.
- `pix_data`  out  24  registered pixel for the column presented one cycle earlier.
- `busy`  out  1  high in REQ or FILL.
- `line_ready`  out  1  back bank full and waiting for `swap`.
- `underrun`  out  1  sticky: `swap` arrived before the fill completed.

## Operation
- Storage: two banks, each `SCREEN_W` x 24. `rd_bank` selects the front bank; the back bank is `~rd_bank`.
- FSM states: IDLE, REQ, FILL, DONE.
  - IDLE: `fetch_req` latches `fetch_y` into `VGA_y` and moves to REQ.
  - REQ: `VGA_re`=1 for exactly this one cycle, then FILL. The arbiter samples `VGA_re` immediately, so the request is a single-cycle pulse, never a level. Holding `VGA_re` would re-trigger the arbiter.
  - FILL: every `VGA_we` with `VGA_x` < `SCREEN_W` writes `VGA_data` into `back[VGA_x]`. A write with `VGA_x` = `SCREEN_W`-1 moves to DONE. Writes with `VGA_x` >= `SCREEN_W` are ignored.
  - DONE: `line_ready`=1. `swap` toggles `rd_bank` and moves to IDLE.
- `VGA_we` outside FILL is ignored; no bank is modified.
- `fetch_req` outside IDLE is ignored, with one exception: DONE with `swap` in the same cycle. In that case the swap is applied first, `fetch_y` is latched, and the next state is REQ. The fetch targets the new back bank.
- `swap` outside DONE: `rd_bank` is unchanged, the front line repeats, and `underrun` is set. `underrun` clears only on reset.
- `swap` in the same cycle as the final FILL write: the write completes, the swap is applied, the next state is IDLE, and `underrun` is not set.
- Read path: `pix_data` <= `front[pix_x]` when `disp_active`=1 and `pix_x` < `SCREEN_W`, otherwise 0. A `swap` in cycle t affects reads issued in t+1 onward.

## Timing
- Reset values: state IDLE, `VGA_re`=0, `VGA_y`=0, `rd_bank`=0, `pix_data`=0, `busy`=0, `line_ready`=0, `underrun`=0. Bank contents are undefined.
- Request latency: `fetch_req` at cycle t gives `VGA_re`=1 and the new `VGA_y` at t+1.
- Arbiter burst: the arbiter's first write (x=0) arrives no earlier than t+2. A full row takes `SCREEN_W` write cycles. `line_ready` rises the cycle after the x=`SCREEN_W`-1 write.
- Read latency is one cycle, fully pipelined: one pixel per clock.
- `VGA_y` changes only when a fetch is accepted.
- Reset asserted mid-fill: everything returns to reset values immediately. The arbiter completes its burst into an IDLE block, and those writes are ignored.

## Test plan
- Reset: assert `rst_n`=0 mid-FILL -> all outputs at reset values asynchronously. After release, `VGA_we` bursts produce no bank change and `pix_data`=0.
- Basic line: `fetch_req` with `fetch_y`=5 -> `VGA_re` pulses exactly 1 cycle at t+1 with `VGA_y`=5. Drive 640 writes with data = {x[7:0], ~x[7:0], 8'h5A} -> `line_ready`=1. Then `swap`, then sweep `pix_x` 0..639 with `disp_active`=1 -> `pix_data` matches the pattern one cycle later.
- Bounds: `pix_x`=640 or `disp_active`=0 -> `pix_data`=0. A write with `VGA_x`=640 during FILL -> no bank change and the state stays FILL.
- Underrun: `swap` while FILL at x=300 -> `underrun`=1 and the old line is still displayed. Later, after DONE and a `swap` -> the new line is displayed and `underrun` stays 1.
- Simultaneous: `swap`+`fetch_req` in DONE -> banks flip, `VGA_re` pulses the next cycle, and the refill does not corrupt the front bank being read.
- Race: `swap` in the same cycle as the x=639 write -> the swap is applied, the next state is IDLE, `underrun`=0, and pixel 639 reads correctly.
